// File: rtl/commit_unit_pkg.sv
// rtl/commit_unit_pkg.sv - shared entry-type, state encodings and widths for the commit unit
package commit_unit_pkg;

    // ROB index width shared by every ROB-facing port.
    localparam int ROB_R = 4;

    // ROB head entry types.
    typedef enum logic [1:0] {
        CT_REG    = 2'd0,
        CT_STORE  = 2'd1,
        CT_BRANCH = 2'd2,
        CT_HALT   = 2'd3
    } ct_e;

    // Commit sequencer states.
    typedef enum logic [1:0] {
        CU_RUN     = 2'd0,
        CU_ST_WAIT = 2'd1,
        CU_FLUSH   = 2'd2,
        CU_HALT    = 2'd3
    } cu_state_e;

    // Entry types that write their result into the register file.
    function automatic logic writes_reg(input logic [1:0] t);
        return (t == CT_REG) || (t == CT_BRANCH);
    endfunction

endpackage

// File: rtl/commit_unit_if.sv
// rtl/commit_unit_if.sv - ROB head, regfile write, store commit and flush/redirect bundle
// master: the commit unit (drives pop, set_*, st_commit_*, rob_clear, redirect_*).
// slave : the surrounding core (ROB head, LSB ack) or a testbench.
interface commit_unit_if #(
    parameter int ROB_W = 4,
    parameter int XLEN  = 32
);
    // ROB head
    logic             head_valid;
    logic             head_ready;
    logic [ROB_W-1:0] head_id;
    logic [1:0]       head_type;
    logic [4:0]       head_rd;
    logic [XLEN-1:0]  head_val;
    logic             head_mispredict;
    logic [XLEN-1:0]  head_target;
    logic             head_pop;
    // Register file write
    logic [4:0]       set_id;
    logic [XLEN-1:0]  set_val;
    logic [ROB_W-1:0] set_from_rob_id;
    // Store commit handshake with the LSB
    logic             st_commit_req;
    logic [ROB_W-1:0] st_commit_id;
    logic             st_commit_ack;
    // Flush and PC redirect
    logic             rob_clear;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;

    modport master (
        input  head_valid, head_ready, head_id, head_type, head_rd, head_val,
               head_mispredict, head_target, st_commit_ack,
        output head_pop, set_id, set_val, set_from_rob_id, st_commit_req,
               st_commit_id, rob_clear, redirect_valid, redirect_pc
    );

    modport slave (
        output head_valid, head_ready, head_id, head_type, head_rd, head_val,
               head_mispredict, head_target, st_commit_ack,
        input  head_pop, set_id, set_val, set_from_rob_id, st_commit_req,
               st_commit_id, rob_clear, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - in-order retirement sequencer between ROB head and register file
// Ports: clk_in, rst_in (async active-high), rdy_in (global enable),
//        bus (commit_unit_if.master: ROB head, regfile set, store commit, flush/redirect),
//        halted (sticky), commit_count (retired instructions, wraps).
module commit_unit
    import commit_unit_pkg::*;
#(
    parameter int ROB_W = ROB_R,
    parameter int XLEN  = 32
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    commit_unit_if.master  bus,
    output logic           halted,
    output logic [31:0]    commit_count
);

    cu_state_e        state_q, state_d;
    logic             st_commit_req_q, st_commit_req_d;
    logic [ROB_W-1:0] st_commit_id_q, st_commit_id_d;
    logic             rob_clear_q, rob_clear_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             halted_q, halted_d;
    logic [31:0]      commit_count_q, commit_count_d;

    logic retire;
    logic ack_pop;
    logic head_pop;
    logic do_write;

    // A head is examined only in RUN; stores wait for the LSB before popping.
    assign retire   = rdy_in && (state_q == CU_RUN) && bus.head_valid && bus.head_ready;
    assign ack_pop  = rdy_in && (state_q == CU_ST_WAIT) && bus.st_commit_ack;
    assign do_write = retire && writes_reg(bus.head_type);
    assign head_pop = ack_pop || (retire && (bus.head_type != CT_STORE));

    always_comb begin
        state_d          = state_q;
        st_commit_req_d  = st_commit_req_q;
        st_commit_id_d   = st_commit_id_q;
        rob_clear_d      = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        halted_d         = halted_q;
        commit_count_d   = commit_count_q + {31'd0, head_pop};

        if (!rdy_in) begin
            // Frozen: everything, including a pending flush pulse, holds.
            state_d          = state_q;
            rob_clear_d      = rob_clear_q;
            redirect_valid_d = redirect_valid_q;
            commit_count_d   = commit_count_q;
        end else begin
            unique case (state_q)
                CU_RUN: begin
                    if (retire) begin
                        unique case (bus.head_type)
                            CT_BRANCH: begin
                                if (bus.head_mispredict) begin
                                    // Flush one cycle after the link write so the
                                    // regfile's clear priority cannot drop it.
                                    state_d          = CU_FLUSH;
                                    rob_clear_d      = 1'b1;
                                    redirect_valid_d = 1'b1;
                                    redirect_pc_d    = bus.head_target;
                                end
                            end
                            CT_STORE: begin
                                state_d         = CU_ST_WAIT;
                                st_commit_req_d = 1'b1;
                                st_commit_id_d  = bus.head_id;
                            end
                            CT_HALT: begin
                                state_d  = CU_HALT;
                                halted_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                CU_ST_WAIT: begin
                    if (bus.st_commit_ack) begin
                        state_d         = CU_RUN;
                        st_commit_req_d = 1'b0;
                    end
                end
                CU_FLUSH: state_d = CU_RUN;
                CU_HALT:  state_d = CU_HALT;
                default:  state_d = CU_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q          <= CU_RUN;
            st_commit_req_q  <= 1'b0;
            st_commit_id_q   <= '0;
            rob_clear_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            halted_q         <= 1'b0;
            commit_count_q   <= '0;
        end else begin
            state_q          <= state_d;
            st_commit_req_q  <= st_commit_req_d;
            st_commit_id_q   <= st_commit_id_d;
            rob_clear_q      <= rob_clear_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            halted_q         <= halted_d;
            commit_count_q   <= commit_count_d;
        end
    end

    assign bus.head_pop        = head_pop;
    assign bus.set_id          = do_write ? bus.head_rd : 5'd0;
    assign bus.set_val         = do_write ? bus.head_val : '0;
    assign bus.set_from_rob_id = do_write ? bus.head_id : '0;
    assign bus.st_commit_req   = st_commit_req_q;
    assign bus.st_commit_id    = st_commit_id_q;
    assign bus.rob_clear       = rob_clear_q;
    assign bus.redirect_valid  = redirect_valid_q;
    assign bus.redirect_pc     = redirect_pc_q;
    assign halted              = halted_q;
    assign commit_count        = commit_count_q;

endmodule
